// File: rtl/grant_decoder_3to8_pkg.sv
// Shared types and constants for the request/grant path.
// Index width, grant width, FSM states and index-to-one-hot helper.
package grant_decoder_3to8_pkg;

  localparam int N_OUT  = 8;
  localparam int CODE_W = 3;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;

  function automatic logic [N_OUT-1:0] onehot_from_index(
    input logic [CODE_W-1:0] idx
  );
    logic [N_OUT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/grant_decoder_3to8_if.sv
// Index handshake plus grant/ack bundle between the
// encoder side (master) and the grant decoder (slave).
interface grant_decoder_3to8_if;
  import grant_decoder_3to8_pkg::*;

  logic [CODE_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [N_OUT-1:0]  dout;
  logic              grant_valid;
  logic [N_OUT-1:0]  ack;
  logic              done;
  logic              timeout;
  logic              busy;

  modport master (
    output din,
    output din_valid,
    output ack,
    input  din_ready,
    input  dout,
    input  grant_valid,
    input  done,
    input  timeout,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    input  ack,
    output din_ready,
    output dout,
    output grant_valid,
    output done,
    output timeout,
    output busy
  );

endinterface

// File: rtl/grant_decoder_3to8_timer.sv
// Saturating grant-age counter; expire flags the last
// permitted cycle of a grant.
module grant_timer #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign expire = en & (cnt == LAST);

  // Holds at LAST so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/grant_decoder_3to8.sv
// 3-to-8 grant decoder: holds a one-hot grant until the
// selected requester acks or the grant ages out.
module grant_decoder_3to8
  import grant_decoder_3to8_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic                   clk,
  input logic                   rst,
  grant_decoder_3to8_if.slave   bus
);

  state_t            state;
  logic [CODE_W-1:0] code;
  logic [N_OUT-1:0]  grant;
  logic              done_q;
  logic              timeout_q;
  logic              accept;
  logic              hit;
  logic              expire;

  assign bus.din_ready   = (state == IDLE) & ~rst;
  assign accept          = bus.din_valid & bus.din_ready;
  assign hit             = (state == GRANT) & bus.ack[code];

  assign bus.dout        = grant;
  assign bus.grant_valid = |grant;
  assign bus.busy        = |grant;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;

  grant_timer #(
    .W     (TO_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     ((state == GRANT) & ~hit),
    .expire (expire)
  );

  // Ack is checked before expiry so a last-cycle ack still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      code      <= '0;
      grant     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            code  <= bus.din;
            grant <= onehot_from_index(bus.din);
            state <= GRANT;
          end
        end
        (state == GRANT): begin
          if (hit) begin
            grant  <= '0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (expire) begin
            grant     <= '0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
